// File: rtl/led_matrix_decoder_pkg.sv
// Shared definitions for the 10-bit pixel-command bus and the dot-matrix geometry.
// The game-core encoders import this same package, so the bus layout lives only here.
package led_matrix_decoder_pkg;

    localparam int MATRIX_ROWS = 16;
    localparam int MATRIX_COLS = 8;
    localparam int ROW_W       = 4;
    localparam int COL_W       = 3;
    localparam int PIX_W       = 10;

    typedef enum logic [1:0] {
        COLOUR_NOOP = 2'b00,
        COLOUR_GRN  = 2'b01,
        COLOUR_RED  = 2'b10,
        COLOUR_BOTH = 2'b11
    } colour_e;

    // Bus layout, MSB first: {colour[1:0], rsvd, row[3:0], col[2:0]}
    typedef struct packed {
        colour_e            colour;
        logic               rsvd;
        logic [ROW_W-1:0]   row;
        logic [COL_W-1:0]   col;
    } pix_cmd_t;

    // One buffered row: {red[7:0], green[7:0]}
    typedef logic [2*MATRIX_COLS-1:0] row_bits_t;

    // Bits to OR into a row for one command; red in the upper byte, green in the lower.
    function automatic row_bits_t pix_row_bits(input logic [1:0] colour, input logic [COL_W-1:0] col);
        row_bits_t bits;
        bits = '0;
        bits[MATRIX_COLS + int'(col)] = colour[1];
        bits[int'(col)]               = colour[0];
        return bits;
    endfunction

endpackage

// File: rtl/led_row_scanner.sv
// Row-scan engine: slot divider, row counter, per-slot column latch and anti-ghost blanking.
module led_row_scanner
    import led_matrix_decoder_pkg::*;
#(
    parameter int SCAN_DIV = 2000,
    parameter int BLANK    = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [MATRIX_ROWS-1:0][2*MATRIX_COLS-1:0]  frame,
    output logic [MATRIX_ROWS-1:0]                     row_sel,
    output logic [MATRIX_COLS-1:0]                     col_r,
    output logic [MATRIX_COLS-1:0]                     col_g
);

    localparam int              DIV_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK);

    logic [DIV_W-1:0] div, div_nxt;
    logic [ROW_W-1:0] row, row_nxt;
    row_bits_t        latch, latch_nxt;

    // Advance the divider; on the last cycle of a slot move to the next row and capture its data,
    // so a buffer swap mid-slot never tears the row currently being shown.
    always_comb begin
        div_nxt   = div + DIV_W'(1);
        row_nxt   = row;
        latch_nxt = latch;
        if (div == DIV_LAST) begin
            div_nxt   = '0;
            row_nxt   = row + ROW_W'(1);
            latch_nxt = frame[row_nxt];
        end
    end

    // Scan state and registered drive outputs; columns held dark for the first BLANK cycles of a slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div     <= '0;
            row     <= '0;
            latch   <= '0;
            row_sel <= MATRIX_ROWS'(1);
            col_r   <= '0;
            col_g   <= '0;
        end else begin
            div     <= div_nxt;
            row     <= row_nxt;
            latch   <= latch_nxt;
            row_sel <= MATRIX_ROWS'(1) << row_nxt;
            if (div_nxt < BLANK_END) begin
                col_r <= '0;
                col_g <= '0;
            end else begin
                col_r <= latch_nxt[2*MATRIX_COLS-1:MATRIX_COLS];
                col_g <= latch_nxt[MATRIX_COLS-1:0];
            end
        end
    end

endmodule

// File: rtl/led_matrix_decoder.sv
// Pixel-command decoder: OR-accumulates strobed commands into a write buffer, swaps it to the
// display buffer on frame sync, and hands the display buffer to the row scanner.
module led_matrix_decoder
    import led_matrix_decoder_pkg::*;
#(
    parameter int SCAN_DIV = 2000,
    parameter int BLANK    = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [PIX_W-1:0]        PIX_IN,
    input  logic                    PIX_STB,
    input  logic                    FRAME_SYNC,
    output logic [MATRIX_ROWS-1:0]  ROW_SEL,
    output logic [MATRIX_COLS-1:0]  COL_R,
    output logic [MATRIX_COLS-1:0]  COL_G,
    output logic [7:0]              PIX_CNT,
    output logic                    FRAME_TGL
);

    pix_cmd_t cmd;
    logic     counted;
    logic     unused_rsvd;
    logic [7:0] cnt, cnt_upd;
    logic [MATRIX_ROWS-1:0][2*MATRIX_COLS-1:0] wbuf, wbuf_upd, dbuf;

    assign cmd         = pix_cmd_t'(PIX_IN);
    assign unused_rsvd = cmd.rsvd;
    assign counted     = PIX_STB && (cmd.colour != COLOUR_NOOP);

    // Write buffer and pixel count as they stand including this cycle's command, so a strobe
    // coinciding with frame sync still lands in the frame being swapped out.
    always_comb begin
        wbuf_upd = wbuf;
        cnt_upd  = cnt;
        if (counted) begin
            wbuf_upd[cmd.row] = wbuf[cmd.row] | pix_row_bits(cmd.colour, cmd.col);
            if (cnt != 8'hFF) begin
                cnt_upd = cnt + 8'd1;
            end
        end
    end

    // Frame buffers, pixel counter and swap-side status outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wbuf      <= '0;
            dbuf      <= '0;
            cnt       <= '0;
            PIX_CNT   <= '0;
            FRAME_TGL <= 1'b0;
        end else if (FRAME_SYNC) begin
            dbuf      <= wbuf_upd;
            wbuf      <= '0;
            PIX_CNT   <= cnt_upd;
            cnt       <= '0;
            FRAME_TGL <= ~FRAME_TGL;
        end else begin
            wbuf      <= wbuf_upd;
            cnt       <= cnt_upd;
        end
    end

    led_row_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .BLANK    (BLANK)
    ) u_scanner (
        .clk     (CLK),
        .rst     (RST),
        .frame   (dbuf),
        .row_sel (ROW_SEL),
        .col_r   (COL_R),
        .col_g   (COL_G)
    );

endmodule

// File: tb/tb_led_matrix_decoder.sv
// Directed bench for led_matrix_decoder, run with a short scan slot to keep frames quick.
module tb_led_matrix_decoder;

    localparam int SD = 32;
    localparam int BL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  pix_in;
    logic        pix_stb;
    logic        frame_sync;
    logic [15:0] row_sel;
    logic [7:0]  col_r;
    logic [7:0]  col_g;
    logic [7:0]  pix_cnt;
    logic        frame_tgl;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_tgl  = 1'b0;

    led_matrix_decoder #(.SCAN_DIV(SD), .BLANK(BL)) dut (
        .CLK        (clk),
        .RST        (rst),
        .PIX_IN     (pix_in),
        .PIX_STB    (pix_stb),
        .FRAME_SYNC (frame_sync),
        .ROW_SEL    (row_sel),
        .COL_R      (col_r),
        .COL_G      (col_g),
        .PIX_CNT    (pix_cnt),
        .FRAME_TGL  (frame_tgl)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] c);
        pix_in  = c;
        pix_stb = 1'b1;
        tick();
        pix_stb = 1'b0;
        pix_in  = '0;
    endtask

    task automatic sync();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        exp_tgl    = ~exp_tgl;
    endtask

    // Step until the start of the named row's slot (ROW_SEL newly equal to its one-hot).
    task automatic wait_row(input int r, output bit ok);
        logic [15:0] tgt;
        logic [15:0] prev;
        tgt  = 16'h0001 << r;
        ok   = 1'b0;
        prev = row_sel;
        for (int i = 0; i < 17 * SD; i++) begin
            tick();
            if (row_sel == tgt && prev != tgt) begin
                ok = 1'b1;
                break;
            end
            prev = row_sel;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pix_stb = 1'b0; frame_sync = 1'b0; pix_in = '0; exp_tgl = 1'b0;
        tick();
        n_checks++; if (row_sel !== 16'h0001) begin n_fail++; $display("FAIL reset_row_sel: got %h expected 0001", row_sel); end
        n_checks++; if (col_r !== 8'h00) begin n_fail++; $display("FAIL reset_col_r: got %h expected 00", col_r); end
        n_checks++; if (col_g !== 8'h00) begin n_fail++; $display("FAIL reset_col_g: got %h expected 00", col_g); end
        n_checks++; if (pix_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_pix_cnt: got %h expected 00", pix_cnt); end
        n_checks++; if (frame_tgl !== 1'b0) begin n_fail++; $display("FAIL reset_frame_tgl: got %b expected 0", frame_tgl); end
        rst = 1'b0;
        repeat (SD - 1) tick();
        n_checks++; if (row_sel !== 16'h0001) begin n_fail++; $display("FAIL scan_slot_end: got %h expected 0001", row_sel); end
        tick();
        n_checks++; if (row_sel !== 16'h0002) begin n_fail++; $display("FAIL scan_step: got %h expected 0002", row_sel); end
        repeat (14 * SD) tick();
        n_checks++; if (row_sel !== 16'h8000) begin n_fail++; $display("FAIL scan_row15: got %h expected 8000", row_sel); end
        repeat (SD) tick();
        n_checks++; if (row_sel !== 16'h0001) begin n_fail++; $display("FAIL scan_wrap: got %h expected 0001", row_sel); end
    endtask

    task automatic test_single_red();
        bit ok;
        send(10'b10_0_1100_011);
        sync();
        n_checks++; if (pix_cnt !== 8'd1) begin n_fail++; $display("FAIL red_pix_cnt: got %0d expected 1", pix_cnt); end
        n_checks++; if (frame_tgl !== exp_tgl) begin n_fail++; $display("FAIL red_frame_tgl: got %b expected %b", frame_tgl, exp_tgl); end
        wait_row(12, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL red_wait_row12: got timeout expected slot start"); end
        repeat (BL - 1) tick();
        n_checks++; if (col_r !== 8'h00) begin n_fail++; $display("FAIL red_blanking: got %h expected 00", col_r); end
        tick();
        n_checks++; if (col_r !== 8'h08) begin n_fail++; $display("FAIL red_col_r: got %h expected 08", col_r); end
        n_checks++; if (col_g !== 8'h00) begin n_fail++; $display("FAIL red_col_g: got %h expected 00", col_g); end
    endtask

    task automatic test_red_green();
        bit ok;
        send(10'b10_0_1100_011);
        send(10'b01_0_1100_011);
        send(10'b00_0_0001_001);
        send(10'b00_1_1111_111);
        send(10'b11_1_0101_111);
        sync();
        n_checks++; if (pix_cnt !== 8'd3) begin n_fail++; $display("FAIL rg_pix_cnt: got %0d expected 3", pix_cnt); end
        n_checks++; if (frame_tgl !== exp_tgl) begin n_fail++; $display("FAIL rg_frame_tgl: got %b expected %b", frame_tgl, exp_tgl); end
        wait_row(5, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rg_wait_row5: got timeout expected slot start"); end
        repeat (BL) tick();
        n_checks++; if (col_r !== 8'h80) begin n_fail++; $display("FAIL both_col_r: got %h expected 80", col_r); end
        n_checks++; if (col_g !== 8'h80) begin n_fail++; $display("FAIL both_col_g: got %h expected 80", col_g); end
        wait_row(12, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rg_wait_row12: got timeout expected slot start"); end
        repeat (BL) tick();
        n_checks++; if (col_r !== 8'h08) begin n_fail++; $display("FAIL rg_col_r: got %h expected 08", col_r); end
        n_checks++; if (col_g !== 8'h08) begin n_fail++; $display("FAIL rg_col_g: got %h expected 08", col_g); end
    endtask

    task automatic test_same_cycle();
        bit ok;
        pix_in = 10'b10_0_0010_000; pix_stb = 1'b1; frame_sync = 1'b1;
        tick();
        pix_in = '0; pix_stb = 1'b0; frame_sync = 1'b0; exp_tgl = ~exp_tgl;
        n_checks++; if (pix_cnt !== 8'd1) begin n_fail++; $display("FAIL same_pix_cnt: got %0d expected 1", pix_cnt); end
        n_checks++; if (frame_tgl !== exp_tgl) begin n_fail++; $display("FAIL same_frame_tgl: got %b expected %b", frame_tgl, exp_tgl); end
        wait_row(2, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL same_wait_row2: got timeout expected slot start"); end
        repeat (BL) tick();
        n_checks++; if (col_r !== 8'h01) begin n_fail++; $display("FAIL same_col_r: got %h expected 01", col_r); end
        sync();
        n_checks++; if (pix_cnt !== 8'd0) begin n_fail++; $display("FAIL empty_pix_cnt: got %0d expected 0", pix_cnt); end
        wait_row(2, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL empty_wait_row2: got timeout expected slot start"); end
        repeat (BL) tick();
        n_checks++; if (col_r !== 8'h00) begin n_fail++; $display("FAIL empty_col_r: got %h expected 00", col_r); end
        n_checks++; if (col_g !== 8'h00) begin n_fail++; $display("FAIL empty_col_g: got %h expected 00", col_g); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        send(10'b11_0_0000_000);
        sync();
        n_checks++; if (pix_cnt !== 8'd1) begin n_fail++; $display("FAIL b2b_first_cnt: got %0d expected 1", pix_cnt); end
        n_checks++; if (frame_tgl !== exp_tgl) begin n_fail++; $display("FAIL b2b_first_tgl: got %b expected %b", frame_tgl, exp_tgl); end
        sync();
        n_checks++; if (pix_cnt !== 8'd0) begin n_fail++; $display("FAIL b2b_second_cnt: got %0d expected 0", pix_cnt); end
        n_checks++; if (frame_tgl !== exp_tgl) begin n_fail++; $display("FAIL b2b_second_tgl: got %b expected %b", frame_tgl, exp_tgl); end
        wait_row(0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_wait_row0: got timeout expected slot start"); end
        repeat (BL) tick();
        n_checks++; if ({col_r, col_g} !== 16'h0000) begin n_fail++; $display("FAIL b2b_cols: got %h expected 0000", {col_r, col_g}); end
    endtask

    task automatic test_saturate();
        bit ok;
        repeat (300) send(10'b01_0_0111_001);
        sync();
        n_checks++; if (pix_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_pix_cnt: got %0d expected 255", pix_cnt); end
        wait_row(7, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL sat_wait_row7: got timeout expected slot start"); end
        repeat (BL + 2) tick();
        n_checks++; if (col_g !== 8'h02) begin n_fail++; $display("FAIL sat_col_g: got %h expected 02", col_g); end
        n_checks++; if (col_r !== 8'h00) begin n_fail++; $display("FAIL sat_col_r: got %h expected 00", col_r); end
        sync();
        n_checks++; if (pix_cnt !== 8'd0) begin n_fail++; $display("FAIL midslot_pix_cnt: got %0d expected 0", pix_cnt); end
        repeat (SD - BL - 5) tick();
        n_checks++; if (row_sel !== 16'h0080) begin n_fail++; $display("FAIL midslot_row_sel: got %h expected 0080", row_sel); end
        n_checks++; if (col_g !== 8'h02) begin n_fail++; $display("FAIL midslot_no_tear: got %h expected 02", col_g); end
        wait_row(7, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL midslot_wait_row7: got timeout expected slot start"); end
        repeat (BL) tick();
        n_checks++; if (col_g !== 8'h00) begin n_fail++; $display("FAIL midslot_next_frame: got %h expected 00", col_g); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        send(10'b10_0_0100_110);
        sync();
        wait_row(4, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_wait_row4: got timeout expected slot start"); end
        repeat (BL + 3) tick();
        n_checks++; if (col_r !== 8'h40) begin n_fail++; $display("FAIL rmid_pre_col_r: got %h expected 40", col_r); end
        send(10'b10_0_0100_001);
        rst = 1'b1;
        #1;
        exp_tgl = 1'b0;
        n_checks++; if (row_sel !== 16'h0001) begin n_fail++; $display("FAIL rmid_row_sel: got %h expected 0001", row_sel); end
        n_checks++; if (col_r !== 8'h00) begin n_fail++; $display("FAIL rmid_col_r: got %h expected 00", col_r); end
        n_checks++; if (pix_cnt !== 8'd0) begin n_fail++; $display("FAIL rmid_pix_cnt: got %0d expected 0", pix_cnt); end
        n_checks++; if (frame_tgl !== 1'b0) begin n_fail++; $display("FAIL rmid_frame_tgl: got %b expected 0", frame_tgl); end
        tick();
        tick();
        rst = 1'b0;
        sync();
        n_checks++; if (pix_cnt !== 8'd0) begin n_fail++; $display("FAIL rmid_sync_cnt: got %0d expected 0", pix_cnt); end
        n_checks++; if (frame_tgl !== exp_tgl) begin n_fail++; $display("FAIL rmid_sync_tgl: got %b expected %b", frame_tgl, exp_tgl); end
        wait_row(4, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_wait_row4b: got timeout expected slot start"); end
        repeat (BL) tick();
        n_checks++; if ({col_r, col_g} !== 16'h0000) begin n_fail++; $display("FAIL rmid_blank_frame: got %h expected 0000", {col_r, col_g}); end
    endtask

    initial begin
        rst        = 1'b1;
        pix_in     = '0;
        pix_stb    = 1'b0;
        frame_sync = 1'b0;
        test_reset();
        test_single_red();
        test_red_green();
        test_same_cycle();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
